// File: rtl/hash_msg_feeder.sv
// Front-end for the full-hash DES-S-box core: takes a length descriptor and a byte
// stream, paces one byte per core slot, waits out the core latency and returns the digest.
module hash_msg_feeder #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             desc_valid,
    output logic             desc_ready,
    input  logic [LEN_W-1:0] desc_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             M_valid,
    output logic [7:0]       message,
    output logic [LEN_W-1:0] counter,
    input  logic [31:0]      core_digest,
    input  logic             core_hash_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_digest,
    output logic             out_len_err,
    output logic             out_sync_err,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        GAP   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [7:0]       fifo_mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      fifo_cnt_q;
    logic             fifo_full, fifo_empty;
    logic [LEN_W-1:0] counter_q, rx_cnt_q, tx_cnt_q;
    logic [1:0]       drain_q;
    logic             m_valid_q;
    logic [7:0]       message_q;
    logic             len_err_q, sync_err_q;
    logic [31:0]      digest_q;
    logic             desc_take, empty_msg, push, pop, capture, last_idx;

    // All three ports (desc, in, out) transfer on a rising edge where valid and ready
    // are both high; ready never depends on the same port's valid.
    assign fifo_full  = (fifo_cnt_q == FULL_CNT);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign desc_ready = (state_q == IDLE);
    assign desc_take  = desc_valid && desc_ready;
    assign empty_msg  = desc_take && (desc_len == '0);
    assign in_ready   = (state_q inside {FEED, GAP, DRAIN}) && !fifo_full && (rx_cnt_q < counter_q);
    assign push       = in_valid && in_ready;
    assign pop        = (state_q == FEED) && !fifo_empty;
    assign capture    = (state_q == DRAIN) && (drain_q == 2'd0);
    assign last_idx   = (rx_cnt_q == counter_q - LEN_W'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (desc_take) state_d = (desc_len == '0) ? DRAIN : FEED;
            FEED:    if (pop) state_d = GAP;
            GAP:     state_d = (tx_cnt_q < counter_q) ? FEED : DRAIN;
            DRAIN:   if (drain_q == 2'd0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= in_data;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // M_valid is registered, so the pulse appears the cycle after the pop (or descriptor);
    // drain=2 then lines the capture up with the core's digest-valid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q  <= 1'b0;
            message_q  <= '0;
            counter_q  <= '0;
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            drain_q    <= '0;
            len_err_q  <= 1'b0;
            sync_err_q <= 1'b0;
            digest_q   <= '0;
        end else begin
            m_valid_q <= pop || empty_msg;
            if (pop)            message_q <= fifo_mem[rd_ptr_q];
            else if (empty_msg) message_q <= 8'h00;
            if (desc_take) begin
                counter_q  <= desc_len;
                rx_cnt_q   <= '0;
                tx_cnt_q   <= '0;
                len_err_q  <= 1'b0;
                sync_err_q <= 1'b0;
            end
            if (push) begin
                rx_cnt_q <= rx_cnt_q + LEN_W'(1);
                if (in_last != last_idx) len_err_q <= 1'b1;
            end
            if (pop) tx_cnt_q <= tx_cnt_q + LEN_W'(1);
            if (empty_msg || (state_q == GAP && state_d == DRAIN)) drain_q <= 2'd2;
            else if (state_q == DRAIN && drain_q != 2'd0)          drain_q <= drain_q - 2'd1;
            if (capture) begin
                digest_q   <= core_digest;
                sync_err_q <= !core_hash_ready;
            end
        end
    end

    assign M_valid      = m_valid_q;
    assign message      = message_q;
    assign counter      = counter_q;
    assign out_valid    = (state_q == DONE);
    assign out_digest   = digest_q;
    assign out_len_err  = len_err_q;
    assign out_sync_err = sync_err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Directed bench for hash_msg_feeder with a cycle-accurate stand-in for the hash core
// (FNV-1a digest, ready only in the cycle the real core would present its result).
module tb_hash_msg_feeder;

    localparam int          DEPTH     = 4;
    localparam int          LEN_W     = 64;
    localparam logic [31:0] H_INIT    = 32'h811C_9DC5;
    localparam logic [31:0] BURST_PAT = 32'hFFFF_F1FF;

    logic             clk, rst_n;
    logic             desc_valid, desc_ready;
    logic [LEN_W-1:0] desc_len;
    logic             in_valid, in_ready, in_last;
    logic [7:0]       in_data;
    logic             M_valid;
    logic [7:0]       message;
    logic [LEN_W-1:0] counter;
    logic [31:0]      core_digest;
    logic             core_hash_ready;
    logic             out_valid, out_ready;
    logic [31:0]      out_digest;
    logic             out_len_err, out_sync_err, busy;

    int n_cmp = 0;
    int n_bad = 0;

    hash_msg_feeder #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_len(desc_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .M_valid(M_valid), .message(message), .counter(counter),
        .core_digest(core_digest), .core_hash_ready(core_hash_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_digest(out_digest),
        .out_len_err(out_len_err), .out_sync_err(out_sync_err), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- core stand-in ----------------
    function automatic logic [31:0] fnv_step(input logic [31:0] h, input logic [7:0] b);
        return (h ^ {24'd0, b}) * 32'h0100_0193;
    endfunction

    logic [31:0]      core_acc;
    logic [1:0]       core_cd;
    logic [LEN_W-1:0] core_seen;
    bit               force_nready = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_acc  <= H_INIT;
            core_cd   <= 2'd0;
            core_seen <= '0;
        end else if (M_valid) begin
            if (counter != '0) core_acc <= fnv_step(core_acc, message);
            core_seen <= core_seen + 1'b1;
            if (counter == '0)                    core_cd <= 2'd2;
            else if (core_seen + 1'b1 == counter) core_cd <= 2'd3;
        end else if (core_cd != 2'd0) begin
            core_cd <= core_cd - 2'd1;
            if (core_cd == 2'd1) begin
                core_acc  <= H_INIT;
                core_seen <= '0;
            end
        end
    end

    assign core_hash_ready = (core_cd == 2'd1) && !force_nready;
    assign core_digest     = (core_cd == 2'd1) ? core_acc : 32'hDEAD_BEEF;

    // ---------------- source / scoreboard state ----------------
    logic [7:0]       src_q[$];
    bit               last_q[$];
    logic [7:0]       exp_q[$];
    int               mv_cyc[$];
    logic [7:0]       mv_byte[$];
    logic [LEN_W-1:0] mv_cnt[$];
    int               t_out, acc_cnt, stall_seen, occ_bad, extra_bad, stable_bad, desc_bad;
    logic [31:0]      got_digest;
    logic             got_len_err, got_sync_err;
    logic [110:0]     rst_vec;
    localparam logic [110:0] RST_EXP = {1'b0, 8'h00, 64'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};

    function automatic logic [31:0] model_digest();
        logic [31:0] h = H_INIT;
        foreach (exp_q[i]) h = fnv_step(h, exp_q[i]);
        return h;
    endfunction

    task automatic clear_msg();
        src_q.delete(); last_q.delete(); exp_q.delete();
    endtask

    task automatic add_byte(input logic [7:0] b, input bit l);
        src_q.push_back(b); last_q.push_back(l); exp_q.push_back(b);
    endtask

    // ---------------- driver ----------------
    // Runs one message: descriptor, byte producer, output consumer; records what it sees.
    // rst_after >= 0 pulls rst_n low once that many bytes have been accepted.
    task automatic send_msg(input logic [LEN_W-1:0] len, input int hold, input bit burst, input int rst_after);
        bit d_pend, i_pend, o_pend, taken, done;
        mv_cyc.delete(); mv_byte.delete(); mv_cnt.delete();
        t_out = -1; acc_cnt = 0; stall_seen = 0; occ_bad = 0; extra_bad = 0; stable_bad = 0; desc_bad = 0;
        got_digest = '0; got_len_err = 1'b0; got_sync_err = 1'b0;
        taken = 1'b0; done = 1'b0;
        @(negedge clk);
        desc_valid = 1'b1; desc_len = len; in_valid = 1'b0; out_ready = 1'b0;
        d_pend = desc_ready; i_pend = 1'b0; o_pend = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (d_pend) begin desc_valid = 1'b0; taken = 1'b1; end
            if (i_pend) begin void'(src_q.pop_front()); void'(last_q.pop_front()); acc_cnt++; end
            if (o_pend) done = 1'b1;
            else if (rst_after >= 0 && acc_cnt == rst_after) begin
                rst_n = 1'b0; done = 1'b1;
            end else begin
                if (M_valid) begin mv_cyc.push_back(c); mv_byte.push_back(message); mv_cnt.push_back(counter); end
                if (taken && desc_ready) desc_bad++;
                if (taken && LEN_W'(acc_cnt) < len && !in_ready) begin
                    stall_seen++;
                    if (acc_cnt - mv_cyc.size() != DEPTH) occ_bad++;
                end
                if (taken && LEN_W'(acc_cnt) >= len && in_ready) extra_bad++;
                if (out_valid) begin
                    if (t_out < 0) begin
                        t_out = c; got_digest = out_digest; got_len_err = out_len_err; got_sync_err = out_sync_err;
                    end else if (out_digest !== got_digest || out_len_err !== got_len_err || out_sync_err !== got_sync_err) begin
                        stable_bad++;
                    end
                end
                in_valid  = (src_q.size() > 0) && (!burst || BURST_PAT[c % 32]);
                in_data   = (src_q.size() > 0) ? src_q[0] : 8'h00;
                in_last   = (last_q.size() > 0) ? last_q[0] : 1'b0;
                out_ready = (t_out >= 0) && (c - t_out >= hold);
                d_pend = desc_valid && desc_ready;
                i_pend = in_valid && in_ready;
                o_pend = out_valid && out_ready;
            end
        end
        desc_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL send_msg_timeout: len %0d not finished after 300 cycles", len); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_vec = {M_valid, message, counter, desc_ready, in_ready, out_valid, out_digest, out_len_err, out_sync_err, busy};
        n_cmp++; if (rst_vec !== RST_EXP) begin n_bad++; $display("FAIL reset_values: got %h want %h", rst_vec, RST_EXP); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_len1();
        logic [31:0] exp_d;
        int          t0;
        clear_msg(); add_byte(8'h61, 1'b1);
        exp_d = model_digest();
        send_msg(1, 0, 1'b0, -1);
        t0 = (mv_cyc.size() > 0) ? mv_cyc[0] : -100;
        n_cmp++; if (mv_cyc.size() !== 1) begin n_bad++; $display("FAIL len1_pulses: got %0d want 1", mv_cyc.size()); end
        n_cmp++; if (mv_byte.size() == 0 || mv_byte[0] !== 8'h61) begin n_bad++; $display("FAIL len1_byte: got %p want 61", mv_byte); end
        n_cmp++; if (mv_cnt.size() == 0 || mv_cnt[0] !== 64'd1) begin n_bad++; $display("FAIL len1_counter: got %p want 1", mv_cnt); end
        n_cmp++; if (t_out - t0 !== 4) begin n_bad++; $display("FAIL len1_latency: got %0d want 4", t_out - t0); end
        n_cmp++; if (got_digest !== exp_d) begin n_bad++; $display("FAIL len1_digest: got %h want %h", got_digest, exp_d); end
        n_cmp++; if ({got_len_err, got_sync_err} !== 2'b00) begin n_bad++; $display("FAIL len1_errs: got %b want 00", {got_len_err, got_sync_err}); end
    endtask

    task automatic test_abc();
        logic [31:0] exp_d;
        logic [7:0]  eb, gb;
        int          n, t_last;
        clear_msg(); add_byte(8'h61, 1'b0); add_byte(8'h62, 1'b0); add_byte(8'h63, 1'b1);
        exp_d = model_digest();
        send_msg(3, 0, 1'b0, -1);
        n_cmp++; if (mv_cyc.size() !== 3) begin n_bad++; $display("FAIL abc_pulses: got %0d want 3", mv_cyc.size()); end
        for (int i = 1; i < mv_cyc.size(); i++) begin
            n_cmp++; if (mv_cyc[i] - mv_cyc[i-1] !== 2) begin n_bad++; $display("FAIL abc_spacing%0d: got %0d want 2", i, mv_cyc[i] - mv_cyc[i-1]); end
        end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            eb = exp_q.pop_front(); gb = (i < mv_byte.size()) ? mv_byte[i] : 8'hxx;
            n_cmp++; if (gb !== eb) begin n_bad++; $display("FAIL abc_byte%0d: got %h want %h", i, gb, eb); end
        end
        t_last = (mv_cyc.size() > 0) ? mv_cyc[mv_cyc.size()-1] : -100;
        n_cmp++; if (t_out - t_last !== 4) begin n_bad++; $display("FAIL abc_latency: got %0d want 4", t_out - t_last); end
        n_cmp++; if (got_digest !== exp_d) begin n_bad++; $display("FAIL abc_digest: got %h want %h", got_digest, exp_d); end
        n_cmp++; if (extra_bad !== 0) begin n_bad++; $display("FAIL abc_in_ready_after_last: got %0d cycles want 0", extra_bad); end
        n_cmp++; if ({desc_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL abc_idle_after: got %b want 10", {desc_ready, busy}); end
    endtask

    task automatic test_empty();
        int t0;
        clear_msg();
        send_msg(0, 0, 1'b0, -1);
        t0 = (mv_cyc.size() > 0) ? mv_cyc[0] : -100;
        n_cmp++; if (mv_cyc.size() !== 1) begin n_bad++; $display("FAIL empty_pulses: got %0d want 1", mv_cyc.size()); end
        n_cmp++; if (mv_byte.size() == 0 || mv_byte[0] !== 8'h00 || mv_cnt[0] !== 64'd0) begin n_bad++; $display("FAIL empty_msg_cnt: got %p %p want 00 0", mv_byte, mv_cnt); end
        n_cmp++; if (t_out - t0 !== 3) begin n_bad++; $display("FAIL empty_latency: got %0d want 3", t_out - t0); end
        n_cmp++; if (got_digest !== H_INIT) begin n_bad++; $display("FAIL empty_digest: got %h want %h", got_digest, H_INIT); end
        n_cmp++; if ({got_len_err, got_sync_err} !== 2'b00) begin n_bad++; $display("FAIL empty_errs: got %b want 00", {got_len_err, got_sync_err}); end
    endtask

    task automatic test_burst_backpressure();
        logic [31:0] exp_d;
        logic [7:0]  eb, gb;
        int          n;
        clear_msg();
        for (int i = 0; i < 8; i++) add_byte(8'h30 + 8'(i), i == 7);
        exp_d = model_digest();
        send_msg(8, 5, 1'b1, -1);
        n_cmp++; if (mv_cyc.size() !== 8) begin n_bad++; $display("FAIL burst_pulses: got %0d want 8", mv_cyc.size()); end
        n_cmp++; if (stall_seen == 0) begin n_bad++; $display("FAIL burst_fifo_full: got %0d stall cycles want >0", stall_seen); end
        n_cmp++; if (occ_bad !== 0) begin n_bad++; $display("FAIL burst_stall_occupancy: got %0d bad cycles want 0", occ_bad); end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            eb = exp_q.pop_front(); gb = (i < mv_byte.size()) ? mv_byte[i] : 8'hxx;
            n_cmp++; if (gb !== eb) begin n_bad++; $display("FAIL burst_byte%0d: got %h want %h", i, gb, eb); end
        end
        n_cmp++; if (got_digest !== exp_d) begin n_bad++; $display("FAIL burst_digest: got %h want %h", got_digest, exp_d); end
        n_cmp++; if (stable_bad !== 0) begin n_bad++; $display("FAIL burst_out_stable: got %0d changes want 0", stable_bad); end
        n_cmp++; if (desc_bad !== 0) begin n_bad++; $display("FAIL burst_desc_ready_busy: got %0d cycles want 0", desc_bad); end
    endtask

    task automatic test_len_err();
        logic [31:0] exp_d;
        logic [7:0]  eb, gb;
        int          n;
        clear_msg();
        for (int i = 0; i < 4; i++) add_byte(8'h41 + 8'(i), i == 2);
        exp_d = model_digest();
        send_msg(4, 0, 1'b0, -1);
        n_cmp++; if (got_len_err !== 1'b1) begin n_bad++; $display("FAIL lenerr_flag: got %b want 1", got_len_err); end
        n_cmp++; if (got_sync_err !== 1'b0) begin n_bad++; $display("FAIL lenerr_sync: got %b want 0", got_sync_err); end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            eb = exp_q.pop_front(); gb = (i < mv_byte.size()) ? mv_byte[i] : 8'hxx;
            n_cmp++; if (gb !== eb) begin n_bad++; $display("FAIL lenerr_byte%0d: got %h want %h", i, gb, eb); end
        end
        n_cmp++; if (got_digest !== exp_d) begin n_bad++; $display("FAIL lenerr_digest: got %h want %h", got_digest, exp_d); end
    endtask

    task automatic test_sync_err();
        logic [31:0] exp_d;
        clear_msg(); add_byte(8'h78, 1'b0); add_byte(8'h79, 1'b1);
        exp_d = model_digest();
        force_nready = 1'b1;
        send_msg(2, 0, 1'b0, -1);
        force_nready = 1'b0;
        n_cmp++; if (got_sync_err !== 1'b1) begin n_bad++; $display("FAIL syncerr_flag: got %b want 1", got_sync_err); end
        n_cmp++; if (got_len_err !== 1'b0) begin n_bad++; $display("FAIL syncerr_len: got %b want 0", got_len_err); end
        n_cmp++; if (got_digest !== exp_d) begin n_bad++; $display("FAIL syncerr_digest: got %h want %h", got_digest, exp_d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_d;
        clear_msg();
        for (int i = 0; i < 5; i++) add_byte(8'h50 + 8'(i), i == 4);
        send_msg(5, 0, 1'b0, 2);
        #1;
        rst_vec = {M_valid, message, counter, desc_ready, in_ready, out_valid, out_digest, out_len_err, out_sync_err, busy};
        n_cmp++; if (rst_vec !== RST_EXP) begin n_bad++; $display("FAIL midreset_values: got %h want %h", rst_vec, RST_EXP); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_msg(); add_byte(8'h68, 1'b0); add_byte(8'h69, 1'b1);
        exp_d = model_digest();
        send_msg(2, 0, 1'b0, -1);
        n_cmp++; if (mv_cyc.size() !== 2) begin n_bad++; $display("FAIL midreset_pulses: got %0d want 2", mv_cyc.size()); end
        n_cmp++; if (got_digest !== exp_d) begin n_bad++; $display("FAIL midreset_digest: got %h want %h", got_digest, exp_d); end
        n_cmp++; if ({got_len_err, got_sync_err} !== 2'b00) begin n_bad++; $display("FAIL midreset_errs: got %b want 00", {got_len_err, got_sync_err}); end
    endtask

    initial begin
        rst_n = 1'b0; desc_valid = 1'b0; desc_len = '0;
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        test_reset();
        test_len1();
        test_abc();
        test_empty();
        test_burst_backpressure();
        test_len_err();
        test_sync_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
